// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Shared types for the unified memory-port arbiter that sits between the
// instruction-fetch stage, the data-memory stage and the single memory port.
//
//   arb_state_t : transaction phase on the memory port
//                 IDLE - no transaction, requesters are sampled here
//                 REQ  - mem_req asserted, waiting for mem_gnt
//                 RESP - request accepted, waiting for mem_rvalid
//   arb_owner_t : which requester owns the transaction in flight
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one req/gnt/rvalid memory port between instruction fetch and the
// data-memory stage. One transaction is in flight at a time; the data stage
// always wins when both ask in the same IDLE cycle. A fetch that is flushed
// while it is on the bus still completes there, but its result is dropped.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   if_req/if_addr      : fetch request and PC, held until if_valid/flush_if
//   flush_if            : branch taken, kills the current or pending fetch
//   if_rdata/if_valid   : fetched word and its one-cycle valid pulse
//   stall_if            : fetch is waiting
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be : load/store request, held until
//                         dm_valid
//   dm_rdata/dm_valid   : load data / store acknowledge, one-cycle pulse
//   stall_mem           : memory stage is waiting
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : memory-port request, all
//                         driven from registers
//   mem_gnt             : memory accepted the request
//   mem_rvalid/mem_rdata: response (also the write acknowledge)
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    input  logic                    flush_if,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_valid,
    output logic                    stall_if,

    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] dm_be,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    dm_valid,
    output logic                    stall_mem,

    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // Control state
    arb_state_t              state_reg,     state_next;
    arb_owner_t              owner_reg,     owner_next;
    logic                    kill_reg,      kill_next;

    // Memory-port request and payload registers
    logic                    mem_req_reg,   mem_req_next;
    logic                    mem_we_reg,    mem_we_next;
    logic [ADDR_WIDTH-1:0]   mem_addr_reg,  mem_addr_next;
    logic [DATA_WIDTH-1:0]   mem_wdata_reg, mem_wdata_next;
    logic [BE_WIDTH-1:0]     mem_be_reg,    mem_be_next;

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        kill_next      = kill_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_be_next    = mem_be_reg;

        if_valid = 1'b0;
        if_rdata = '0;
        dm_valid = 1'b0;
        dm_rdata = '0;

        unique case (state_reg)
            IDLE: begin
                // Data is the older instruction and stalls the front end,
                // so giving it fixed priority cannot starve fetch.
                if (dm_req) begin
                    state_next     = REQ;
                    owner_next     = DATA;
                    mem_we_next    = dm_we;
                    mem_addr_next  = dm_addr;
                    mem_wdata_next = dm_wdata;
                    mem_be_next    = dm_be;
                end else if (if_req && !flush_if) begin
                    // A flush in this cycle means if_addr is the stale PC;
                    // the redirected PC is picked up on the next visit.
                    state_next     = REQ;
                    owner_next     = FETCH;
                    mem_we_next    = 1'b0;
                    mem_addr_next  = if_addr;
                    mem_wdata_next = '0;
                    mem_be_next    = '1;
                end
            end

            REQ: begin
                // The request is never withdrawn: a flushed fetch keeps
                // its slot on the bus and only its result is suppressed.
                if (owner_reg == FETCH && flush_if) begin
                    kill_next = 1'b1;
                end
                if (mem_gnt) begin
                    state_next = RESP;
                end
            end

            RESP: begin
                if (owner_reg == DATA) begin
                    if (mem_rvalid) begin
                        dm_valid = 1'b1;
                        dm_rdata = mem_rdata;
                    end
                end else begin
                    // A flush arriving together with the response still
                    // wins, so the stale word never reaches decode.
                    if (mem_rvalid && !kill_reg && !flush_if) begin
                        if_valid = 1'b1;
                        if_rdata = mem_rdata;
                    end
                    if (flush_if) begin
                        kill_next = 1'b1;
                    end
                end
                if (mem_rvalid) begin
                    state_next = IDLE;
                    kill_next  = 1'b0;
                end
            end

            default: begin
                state_next = IDLE;
                kill_next  = 1'b0;
            end
        endcase

        // mem_req is a register that mirrors "next cycle is REQ", so the
        // port sees a clean flop output rather than a state decode.
        mem_req_next = (state_next == REQ);

        stall_mem = dm_req & ~dm_valid;
        stall_if  = if_req & ~if_valid;
    end

    // -----------------------------------------------------------------------
    // State, owner, kill and payload registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            owner_reg     <= FETCH;
            kill_reg      <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_be_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            kill_reg      <= kill_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_be_reg    <= mem_be_next;
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_be    = mem_be_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives random fetch / load / store / flush traffic into mem_port_arbiter
// and answers the memory port with a randomly delayed slave. Expected
// responses are computed from a reference memory when a request is issued
// and queued; a negedge monitor pops and compares whenever a valid pulse
// appears, and also checks bus payloads, priority and stall outputs.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, flush_if, if_valid, stall_if;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_valid, stall_mem;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .flush_if(flush_if),
        .if_rdata(if_rdata), .if_valid(if_valid), .stall_if(stall_if),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    // ------------------------------------------------------------------
    // Memory contents: fetch region below 0x1000 is a fixed image, data
    // region at 0x2000 starts from a pattern and is updated by stores.
    // ------------------------------------------------------------------
    logic [31:0] ref_mem [int];
    logic [31:0] slv_mem [int];

    function automatic logic [31:0] fetch_img(input logic [31:0] a);
        if (a == 32'h100) return 32'h00500093;
        return (a * 32'h9E3779B1) ^ 32'h00000013;
    endfunction

    function automatic logic [31:0] data_init(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        int idx;
        idx = int'(a >> 2);
        if (ref_mem.exists(idx)) return ref_mem[idx];
        return data_init(a);
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        int idx;
        if (a < 32'h1000) return fetch_img(a);
        idx = int'(a >> 2);
        if (slv_mem.exists(idx)) return slv_mem[idx];
        return data_init(a);
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard queues
    // ------------------------------------------------------------------
    typedef struct {
        logic        we;
        logic [31:0] data;
    } dexp_t;

    dexp_t       dm_q[$];
    logic [31:0] if_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_if_valid"},  32'(if_valid),  32'd0);
        chk({tag, "_if_rdata"},  if_rdata,       32'd0);
        chk({tag, "_stall_if"},  32'(stall_if),  32'd0);
        chk({tag, "_dm_valid"},  32'(dm_valid),  32'd0);
        chk({tag, "_dm_rdata"},  dm_rdata,       32'd0);
        chk({tag, "_stall_mem"}, 32'(stall_mem), 32'd0);
        chk({tag, "_mem_req"},   32'(mem_req),   32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_mem_addr"},  mem_addr,       32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata,      32'd0);
        chk({tag, "_mem_be"},    32'(mem_be),    32'd0);
    endtask

    // ------------------------------------------------------------------
    // Memory slave: random grant and response delays up to max_wait.
    // ------------------------------------------------------------------
    int          max_wait = 0;
    bit          slave_en = 1'b1;

    initial begin : slave
        bit          phase, waiting, acc, rv;
        int          gnt_wait, rv_wait;
        logic        t_we;
        logic [31:0] t_addr, t_wdata;
        logic [3:0]  t_be;
        phase = 0; waiting = 0; gnt_wait = 0; rv_wait = 0;
        t_we = 0; t_addr = 0; t_wdata = 0; t_be = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        forever begin
            @(negedge clk);
            acc = !rst && mem_req && mem_gnt;
            rv  = !rst && mem_rvalid;
            if (acc) begin
                t_we = mem_we; t_addr = mem_addr; t_wdata = mem_wdata; t_be = mem_be;
            end
            @(posedge clk);
            #1;
            if (rst) begin
                phase = 0; waiting = 0;
                mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
            end else begin
                if (!phase && acc) begin
                    phase   = 1;
                    waiting = 0;
                    rv_wait = int'($urandom_range(0, max_wait));
                end else if (phase && rv) begin
                    phase = 0;
                    if (t_we) slv_mem[int'(t_addr >> 2)] = merge(slv_rd(t_addr), t_wdata, t_be);
                end
                mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
                if (!phase && mem_req && slave_en) begin
                    if (!waiting) begin
                        waiting  = 1;
                        gnt_wait = int'($urandom_range(0, max_wait));
                    end
                    if (gnt_wait == 0) mem_gnt = 1;
                    else gnt_wait--;
                end
                if (phase) begin
                    if (rv_wait == 0) begin
                        mem_rvalid = 1;
                        mem_rdata  = t_we ? $urandom() : slv_rd(t_addr);
                    end else begin
                        rv_wait--;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: pops expectations on valid pulses, checks bus payload,
    // priority and stall outputs once per cycle.
    // ------------------------------------------------------------------
    logic dm_seen = 1'b0;
    logic if_seen = 1'b0;

    initial begin : monitor
        dexp_t       de;
        logic [31:0] fe;
        logic        mreq_p, dreq_p, dwe_p, ireq_p, flush_p;
        logic [31:0] daddr_p, dwdata_p, iaddr_p;
        logic [3:0]  dbe_p;
        logic        exp_act, exp_we;
        logic [31:0] exp_addr, exp_wdata;
        logic [3:0]  exp_be;
        mreq_p = 0; dreq_p = 0; dwe_p = 0; ireq_p = 0; flush_p = 0;
        daddr_p = 0; dwdata_p = 0; iaddr_p = 0; dbe_p = 0;
        exp_act = 0; exp_we = 0; exp_addr = 0; exp_wdata = 0; exp_be = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mreq_p = 0; exp_act = 0; dm_seen = 0; if_seen = 0;
            end else begin
                chk("rvalid_outside_resp", 32'(mem_rvalid & mem_req), 32'd0);

                if (dm_valid) begin
                    chk("dm_valid_expected", 32'(dm_q.size() != 0), 32'd1);
                    if (dm_q.size() != 0) begin
                        de = dm_q.pop_front();
                        if (!de.we) chk("dm_rdata", dm_rdata, de.data);
                        $display("txn t=%0t data %s rdata=%h", $time, de.we ? "store" : "load", dm_rdata);
                    end
                end

                if (if_valid) begin
                    chk("if_valid_expected", 32'(if_q.size() != 0), 32'd1);
                    if (if_q.size() != 0) begin
                        fe = if_q.pop_front();
                        chk("if_rdata", if_rdata, fe);
                        $display("txn t=%0t fetch rdata=%h", $time, if_rdata);
                    end
                end

                chk("stall_mem", 32'(stall_mem), 32'(dm_req & ~dm_valid));
                chk("stall_if",  32'(stall_if),  32'(if_req & ~if_valid));

                // A new bus request must come from what IDLE saw last cycle,
                // data first.
                if (mem_req && !mreq_p) begin
                    chk("bus_start_has_requester", 32'(dreq_p | (ireq_p & ~flush_p)), 32'd1);
                    exp_act = 1;
                    if (dreq_p) begin
                        exp_we = dwe_p; exp_addr = daddr_p; exp_wdata = dwdata_p; exp_be = dbe_p;
                    end else begin
                        exp_we = 0; exp_addr = iaddr_p; exp_wdata = 0; exp_be = 4'hF;
                    end
                end
                if (mem_req && exp_act) begin
                    chk("mem_addr", mem_addr, exp_addr);
                    chk("mem_we",   32'(mem_we), 32'(exp_we));
                    chk("mem_be",   32'(mem_be), 32'(exp_be));
                    if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
                end
                if (!mem_req) exp_act = 0;

                mreq_p = mem_req; dreq_p = dm_req; dwe_p = dm_we; daddr_p = dm_addr;
                dwdata_p = dm_wdata; dbe_p = dm_be; ireq_p = if_req; flush_p = flush_if;
                iaddr_p = if_addr;
                dm_seen = dm_valid;
                if_seen = if_valid;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic issue_data();
        dexp_t e;
        dm_addr  = 32'h2000 + 32'($urandom_range(0, 15)) * 4;
        dm_we    = 1'($urandom_range(0, 1));
        dm_wdata = $urandom();
        dm_be    = 4'($urandom_range(1, 15));
        e.we     = dm_we;
        if (dm_we) begin
            ref_mem[int'(dm_addr >> 2)] = merge(ref_rd(dm_addr), dm_wdata, dm_be);
            e.data = 32'd0;
        end else begin
            e.data = ref_rd(dm_addr);
        end
        dm_q.push_back(e);
        dm_req = 1;
    endtask

    task automatic issue_fetch();
        if_addr = 32'($urandom_range(0, 255)) * 4;
        if_q.push_back(fetch_img(if_addr));
        if_req = 1;
    endtask

    task automatic drive_step(input bit allow);
        flush_if = 0;
        if (dm_req && dm_seen) dm_req = 0;
        if (!dm_req && allow && $urandom_range(0, 2) == 0) issue_data();
        if (if_req && if_seen) if_req = 0;
        if (allow && if_req && $urandom_range(0, 11) == 0) begin
            flush_if = 1;
            if_req   = 0;
            if_q.delete();
        end else if (allow && !if_req && $urandom_range(0, 19) == 0) begin
            flush_if = 1;
        end else if (allow && !if_req && $urandom_range(0, 1) == 0) begin
            issue_fetch();
        end
    endtask

    initial begin : main
        int    lat, t_dm, t_if;
        bit    drained;
        dexp_t e;
        rst = 1; if_req = 0; if_addr = 0; flush_if = 0;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0; dm_be = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst = 0;

        // Fetch 0x100 with immediate grant/response: valid in cycle 2.
        max_wait = 0;
        if_addr  = 32'h100;
        if_req   = 1;
        if_q.push_back(fetch_img(32'h100));
        lat = -1;
        for (int k = 0; k < 8 && lat < 0; k++) begin
            @(negedge clk);
            if (k < 2) chk("fetch_stall_if", 32'(stall_if), 32'd1);
            if (if_valid) lat = k;
        end
        chk("fetch_latency", 32'(lat), 32'd2);
        @(posedge clk);
        #1 if_req = 0;

        // Contention: load 0x2000 and fetch 0x104 together; data first.
        dm_addr = 32'h2000; dm_we = 0; dm_be = 4'hF; dm_wdata = 0; dm_req = 1;
        e.we = 0; e.data = ref_rd(32'h2000);
        dm_q.push_back(e);
        if_addr = 32'h104; if_req = 1;
        if_q.push_back(fetch_img(32'h104));
        t_dm = -1; t_if = -1;
        for (int k = 0; k < 12 && (dm_req || if_req); k++) begin
            @(negedge clk);
            if (dm_valid) t_dm = k;
            if (if_valid) t_if = k;
            @(posedge clk);
            #1;
            if (t_dm == k) dm_req = 0;
            if (t_if == k) if_req = 0;
        end
        chk("contention_dm_cycle", 32'(t_dm), 32'd2);
        chk("contention_if_cycle", 32'(t_if), 32'd5);

        // Reset asserted while a fetch sits in REQ.
        slave_en = 0;
        if_addr  = 32'h200;
        if_req   = 1;
        @(negedge clk);
        @(negedge clk);
        chk("req_before_reset", 32'(mem_req), 32'd1);
        #2;
        if_req = 0;
        rst    = 1;
        #1 chk_zero("reset_in_req");
        @(posedge clk);
        #3 rst = 0;
        slave_en = 1;
        @(negedge clk);
        chk_zero("after_reset");

        // Random traffic.
        max_wait = 3;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1 drive_step(1'b1);
        end

        // Let outstanding requests finish.
        drained = 0;
        for (int cyc = 0; cyc < 500 && !drained; cyc++) begin
            @(posedge clk);
            #1 drive_step(1'b0);
            drained = !if_req && !dm_req;
        end
        chk("drain_done", 32'(drained), 32'd1);
        repeat (3) @(negedge clk);
        chk("dm_q_empty", 32'(dm_q.size()), 32'd0);
        chk("if_q_empty", 32'(if_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
